// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP controller that runs entirely in the
// clk_i domain. It oversamples TCK/TMS/TDI/TRST and provides IDCODE, BYPASS
// and a USER data register that exchanges a word with fabric logic.
// Optional build macro: JTAG_TAP_SRST_EN adds instruction 5'b00010, which
// selects a 1-bit SRST data register that drives srst_o.
module jtag_tap_sampled #(
  parameter int          IR_LEN      = 5,
  parameter logic [31:0] IDCODE_VAL  = 32'h1BEEF001,
  parameter int          USER_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  tck_i,
  input  logic                  tms_i,
  input  logic                  tdi_i,
  input  logic                  trst_ni,
  output logic                  tdo_o,
  output logic                  tdo_oe_o,
  output logic [3:0]            tap_state_o,
  input  logic [USER_WIDTH-1:0] user_rd_data_i,
  output logic [USER_WIDTH-1:0] user_wr_data_o,
  output logic                  user_wr_valid_o,
  output logic                  srst_o
);

  typedef enum logic [3:0] {
    S_EXIT2_DR = 4'h0,
    S_EXIT1_DR = 4'h1,
    S_SHIFT_DR = 4'h2,
    S_PAUSE_DR = 4'h3,
    S_SEL_IR   = 4'h4,
    S_UPD_DR   = 4'h5,
    S_CAP_DR   = 4'h6,
    S_SEL_DR   = 4'h7,
    S_EXIT2_IR = 4'h8,
    S_EXIT1_IR = 4'h9,
    S_SHIFT_IR = 4'hA,
    S_PAUSE_IR = 4'hB,
    S_RTI      = 4'hC,
    S_UPD_IR   = 4'hD,
    S_CAP_IR   = 4'hE,
    S_TLR      = 4'hF
  } tapState_e;

  localparam logic [IR_LEN-1:0] C_IR_IDCODE  = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] C_IR_USER    = IR_LEN'(8);
  localparam logic [IR_LEN-1:0] C_IR_CAPTURE = IR_LEN'(1);

  logic [SYNC_STAGES-1:0] r_tckSync;
  logic [SYNC_STAGES-1:0] r_tmsSync;
  logic [SYNC_STAGES-1:0] r_tdiSync;
  logic [SYNC_STAGES-1:0] r_trstSync;
  logic                   r_tckPrev;

  logic w_tck;
  logic w_tms;
  logic w_tdi;
  logic w_trstN;
  logic w_tckRise;
  logic w_tckFall;

  tapState_e r_state;
  tapState_e w_nextState;

  logic [IR_LEN-1:0]     r_irShift;
  logic [IR_LEN-1:0]     r_ir;
  logic [31:0]           r_idShift;
  logic [USER_WIDTH-1:0] r_userShift;
  logic                  r_bypass;
  logic                  r_tdo;
  logic                  r_tdoOe;
  logic [USER_WIDTH-1:0] r_userWrData;
  logic                  r_userWrValid;

  logic w_selIdcode;
  logic w_selUser;
  logic w_drLsb;
  logic w_tdoBit;

`ifdef JTAG_TAP_SRST_EN
  localparam logic [IR_LEN-1:0] C_IR_SRST = IR_LEN'(2);
  logic r_srstShift;
  logic r_srst;
  logic w_selSrst;
`endif

  // Synchronize the asynchronous JTAG pins; TRST chain resets to asserted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tckSync  <= '0;
      r_tmsSync  <= '1;
      r_tdiSync  <= '0;
      r_trstSync <= '0;
      r_tckPrev  <= 1'b0;
    end else begin
      r_tckSync  <= {r_tckSync[SYNC_STAGES-2:0], tck_i};
      r_tmsSync  <= {r_tmsSync[SYNC_STAGES-2:0], tms_i};
      r_tdiSync  <= {r_tdiSync[SYNC_STAGES-2:0], tdi_i};
      r_trstSync <= {r_trstSync[SYNC_STAGES-2:0], trst_ni};
      r_tckPrev  <= r_tckSync[SYNC_STAGES-1];
    end
  end

  assign w_tck     = r_tckSync[SYNC_STAGES-1];
  assign w_tms     = r_tmsSync[SYNC_STAGES-1];
  assign w_tdi     = r_tdiSync[SYNC_STAGES-1];
  assign w_trstN   = r_trstSync[SYNC_STAGES-1];
  assign w_tckRise = w_tck & ~r_tckPrev;
  assign w_tckFall = ~w_tck & r_tckPrev;

  // TAP state register: TRST wins over any TCK edge in the same cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_TLR;
    end else if (!w_trstN) begin
      r_state <= S_TLR;
    end else if (w_tckRise) begin
      r_state <= w_nextState;
    end
  end

  // IEEE 1149.1 next-state function, evaluated with the synchronized TMS
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_TLR:      w_nextState = w_tms ? S_TLR      : S_RTI;
      S_RTI:      w_nextState = w_tms ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   w_nextState = w_tms ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   w_nextState = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_nextState = w_tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: w_nextState = w_tms ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: w_nextState = w_tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: w_nextState = w_tms ? S_UPD_DR   : S_SHIFT_DR;
      S_UPD_DR:   w_nextState = w_tms ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   w_nextState = w_tms ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   w_nextState = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_nextState = w_tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: w_nextState = w_tms ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: w_nextState = w_tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: w_nextState = w_tms ? S_UPD_IR   : S_SHIFT_IR;
      S_UPD_IR:   w_nextState = w_tms ? S_SEL_DR   : S_RTI;
      default:    w_nextState = S_TLR;
    endcase
  end

  assign w_selIdcode = (r_ir == C_IR_IDCODE);
  assign w_selUser   = (r_ir == C_IR_USER);
`ifdef JTAG_TAP_SRST_EN
  assign w_selSrst   = (r_ir == C_IR_SRST);
`endif

  // Pick the bit presented on TDO: IR LSB while in SHIFT_IR, else selected DR LSB
  always_comb begin
    w_drLsb = r_bypass;
    if (w_selIdcode) begin
      w_drLsb = r_idShift[0];
    end else if (w_selUser) begin
      w_drLsb = r_userShift[0];
    end
`ifdef JTAG_TAP_SRST_EN
    else if (w_selSrst) begin
      w_drLsb = r_srstShift;
    end
`endif
    w_tdoBit = (r_state == S_SHIFT_IR) ? r_irShift[0] : w_drLsb;
  end

  // Capture/shift on TCK rise, TDO and updates on TCK fall, TRST overrides edges
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_irShift     <= C_IR_CAPTURE;
      r_ir          <= C_IR_IDCODE;
      r_idShift     <= '0;
      r_userShift   <= '0;
      r_bypass      <= 1'b0;
      r_tdo         <= 1'b0;
      r_tdoOe       <= 1'b0;
      r_userWrData  <= '0;
      r_userWrValid <= 1'b0;
`ifdef JTAG_TAP_SRST_EN
      r_srstShift   <= 1'b0;
      r_srst        <= 1'b0;
`endif
    end else begin
      r_userWrValid <= 1'b0;
      if (!w_trstN) begin
        r_ir    <= C_IR_IDCODE;
        r_tdoOe <= 1'b0;
`ifdef JTAG_TAP_SRST_EN
        r_srst  <= 1'b0;
`endif
      end else if (w_tckRise) begin
        case (r_state)
          S_CAP_IR:   r_irShift <= C_IR_CAPTURE;
          S_SHIFT_IR: r_irShift <= {w_tdi, r_irShift[IR_LEN-1:1]};
          S_CAP_DR: begin
            if (w_selIdcode) begin
              r_idShift <= IDCODE_VAL;
            end else if (w_selUser) begin
              r_userShift <= user_rd_data_i;
            end
`ifdef JTAG_TAP_SRST_EN
            else if (w_selSrst) begin
              r_srstShift <= r_srst;
            end
`endif
            else begin
              r_bypass <= 1'b0;
            end
          end
          S_SHIFT_DR: begin
            if (w_selIdcode) begin
              r_idShift <= {w_tdi, r_idShift[31:1]};
            end else if (w_selUser) begin
              r_userShift <= {w_tdi, r_userShift[USER_WIDTH-1:1]};
            end
`ifdef JTAG_TAP_SRST_EN
            else if (w_selSrst) begin
              r_srstShift <= w_tdi;
            end
`endif
            else begin
              r_bypass <= w_tdi;
            end
          end
          default: ;
        endcase
        if (w_nextState == S_TLR) begin
          r_ir   <= C_IR_IDCODE;
`ifdef JTAG_TAP_SRST_EN
          r_srst <= 1'b0;
`endif
        end
      end else if (w_tckFall) begin
        if ((r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR)) begin
          r_tdo   <= w_tdoBit;
          r_tdoOe <= 1'b1;
        end else begin
          r_tdoOe <= 1'b0;
        end
        if (r_state == S_UPD_IR) begin
          r_ir <= r_irShift;
        end
        if ((r_state == S_UPD_DR) && w_selUser) begin
          r_userWrData  <= r_userShift;
          r_userWrValid <= 1'b1;
        end
`ifdef JTAG_TAP_SRST_EN
        if ((r_state == S_UPD_DR) && w_selSrst) begin
          r_srst <= r_srstShift;
        end
`endif
      end
    end
  end

  assign tdo_o           = r_tdo;
  assign tdo_oe_o        = r_tdoOe;
  assign tap_state_o     = r_state;
  assign user_wr_data_o  = r_userWrData;
  assign user_wr_valid_o = r_userWrValid;
`ifdef JTAG_TAP_SRST_EN
  assign srst_o          = r_srst;
`else
  assign srst_o          = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// tb_jtag_tap_sampled: directed bench for jtag_tap_sampled. Bit-bangs TCK
// slowly relative to clk_i and compares TDO streams and outputs against
// hand-computed values.
module tb_jtag_tap_sampled;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        tck_i;
  logic        tms_i;
  logic        tdi_i;
  logic        trst_ni;
  logic        tdo_o;
  logic        tdo_oe_o;
  logic [3:0]  tap_state_o;
  logic [31:0] user_rd_data_i;
  logic [31:0] user_wr_data_o;
  logic        user_wr_valid_o;
  logic        srst_o;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  jtag_tap_sampled dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .tck_i           (tck_i),
    .tms_i           (tms_i),
    .tdi_i           (tdi_i),
    .trst_ni         (trst_ni),
    .tdo_o           (tdo_o),
    .tdo_oe_o        (tdo_oe_o),
    .tap_state_o     (tap_state_o),
    .user_rd_data_i  (user_rd_data_i),
    .user_wr_data_o  (user_wr_data_o),
    .user_wr_valid_o (user_wr_valid_o),
    .srst_o          (srst_o)
  );

  // 100 MHz system clock
  always #5 clk_i = ~clk_i;

  // Count every clk_i cycle in which the update strobe is high
  always @(negedge clk_i) begin
    if (user_wr_valid_o === 1'b1) validCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One TCK period: set TMS/TDI, sample TDO before the rise, then rise and fall
  task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo, output logic oe);
    @(negedge clk_i);
    tms_i = tms;
    tdi_i = tdi;
    tdo   = tdo_o;
    oe    = tdo_oe_o;
    repeat (2) @(negedge clk_i);
    tck_i = 1'b1;
    repeat (4) @(negedge clk_i);
    tck_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic tmsStep(input logic tms);
    logic b, oe;
    applyStimulus(tms, 1'b0, b, oe);
  endtask

  // From a SHIFT state: n bits LSB first, TMS high on the last bit
  task automatic shiftData(input int n, input logic [31:0] din, output logic [31:0] dout, output logic allOe);
    logic b, oe;
    dout  = '0;
    allOe = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == n - 1, din[i], b, oe);
      dout[i] = b;
      if (oe !== 1'b1) allOe = 1'b0;
    end
  endtask

  task automatic gotoShiftIr();
    tmsStep(1); tmsStep(1); tmsStep(0); tmsStep(0);
  endtask

  task automatic gotoShiftDr();
    tmsStep(1); tmsStep(0); tmsStep(0);
  endtask

  task automatic exitToRti();
    tmsStep(1); tmsStep(0);
  endtask

  task automatic loadIr(input logic [4:0] code);
    logic [31:0] d;
    logic oeAll;
    gotoShiftIr();
    shiftData(5, {27'd0, code}, d, oeAll);
    exitToRti();
  endtask

  initial begin
    logic [31:0] d;
    logic        oeAll;
    logic        b, oe;
    int          base;

    rst_n_i = 1'b0; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; trst_ni = 1'b1;
    user_rd_data_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_state", {28'd0, tap_state_o}, 32'hF);
    checkOutput("rst_tdo", {31'd0, tdo_o}, 32'h0);
    checkOutput("rst_oe", {31'd0, tdo_oe_o}, 32'h0);
    checkOutput("rst_wrdata", user_wr_data_o, 32'h0);
    checkOutput("rst_valid", {31'd0, user_wr_valid_o}, 32'h0);
    checkOutput("rst_srst", {31'd0, srst_o}, 32'h0);
    rst_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    checkOutput("post_rst_state", {28'd0, tap_state_o}, 32'hF);

    // IDCODE readout straight after reset
    tmsStep(0);
    checkOutput("rti_state", {28'd0, tap_state_o}, 32'hC);
    tmsStep(1); tmsStep(0);
    checkOutput("capdr_state", {28'd0, tap_state_o}, 32'h6);
    checkOutput("capdr_oe", {31'd0, tdo_oe_o}, 32'h0);
    tmsStep(0);
    checkOutput("shiftdr_state", {28'd0, tap_state_o}, 32'h2);
    checkOutput("shiftdr_oe", {31'd0, tdo_oe_o}, 32'h1);
    shiftData(32, 32'h0, d, oeAll);
    checkOutput("idcode", d, 32'h1BEEF001);
    checkOutput("idcode_oe_all", {31'd0, oeAll}, 32'h1);
    checkOutput("exit1dr_state", {28'd0, tap_state_o}, 32'h1);
    checkOutput("exit1dr_oe", {31'd0, tdo_oe_o}, 32'h0);
    exitToRti();

    // BYPASS via all-ones IR; IR capture pattern is 00001
    gotoShiftIr();
    checkOutput("shiftir_state", {28'd0, tap_state_o}, 32'hA);
    shiftData(5, 32'h1F, d, oeAll);
    checkOutput("ir_capture", d, 32'h1);
    checkOutput("ir_oe_all", {31'd0, oeAll}, 32'h1);
    exitToRti();
    base = validCount;
    gotoShiftDr();
    shiftData(4, 32'hD, d, oeAll);
    checkOutput("bypass_stream", d, 32'hA);
    exitToRti();
    checkOutput("bypass_no_pulse", validCount - base, 0);

    // USER register exchange
    user_rd_data_i = 32'hA5A5_0F0F;
    loadIr(5'b01000);
    base = validCount;
    gotoShiftDr();
    shiftData(32, 32'hDEAD_BEEF, d, oeAll);
    checkOutput("user_read", d, 32'hA5A5_0F0F);
    checkOutput("user_no_early_pulse", validCount - base, 0);
    tmsStep(1);
    checkOutput("upddr_state", {28'd0, tap_state_o}, 32'h5);
    checkOutput("user_wrdata", user_wr_data_o, 32'hDEAD_BEEF);
    checkOutput("user_one_pulse", validCount - base, 1);
    tmsStep(0);
    checkOutput("user_pulse_once", validCount - base, 1);

    // Abort a DR shift with five TMS=1 rises
    loadIr(5'b11111);
    base = validCount;
    gotoShiftDr();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, b, oe);
    for (int i = 0; i < 5; i++) tmsStep(1);
    checkOutput("tms_tlr_state", {28'd0, tap_state_o}, 32'hF);
    checkOutput("tms_tlr_no_pulse", validCount - base, 0);
    checkOutput("tms_tlr_wrdata_kept", user_wr_data_o, 32'hDEAD_BEEF);
    tmsStep(0);
    gotoShiftDr();
    shiftData(32, 32'h0, d, oeAll);
    checkOutput("tms_tlr_ir_idcode", d, 32'h1BEEF001);
    exitToRti();

    // TRST in the middle of SHIFT_IR
    loadIr(5'b11111);
    gotoShiftIr();
    applyStimulus(1'b0, 1'b1, b, oe);
    applyStimulus(1'b0, 1'b1, b, oe);
    checkOutput("pre_trst_state", {28'd0, tap_state_o}, 32'hA);
    checkOutput("pre_trst_oe", {31'd0, tdo_oe_o}, 32'h1);
    @(negedge clk_i);
    trst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("trst_state", {28'd0, tap_state_o}, 32'hF);
    checkOutput("trst_oe", {31'd0, tdo_oe_o}, 32'h0);
    trst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    tmsStep(0);
    gotoShiftDr();
    shiftData(32, 32'h0, d, oeAll);
    checkOutput("trst_ir_idcode", d, 32'h1BEEF001);
    exitToRti();

    // Instruction 00010: SRST register when enabled, BYPASS otherwise
    loadIr(5'b00010);
    gotoShiftDr();
    shiftData(1, 32'h1, d, oeAll);
    checkOutput("srst_capture", d, 32'h0);
    tmsStep(1);
`ifdef JTAG_TAP_SRST_EN
    checkOutput("srst_set", {31'd0, srst_o}, 32'h1);
`else
    checkOutput("srst_tied", {31'd0, srst_o}, 32'h0);
`endif
    for (int i = 0; i < 4; i++) tmsStep(1);
    checkOutput("srst_tlr_state", {28'd0, tap_state_o}, 32'hF);
    checkOutput("srst_tlr_clear", {31'd0, srst_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sampled.md
Name: jtag_tap_sampled

Overview:
- JTAG TAP responder running entirely in the system clock domain. It oversamples TCK/TMS/TDI/TRST from an external probe or from the USB JTAG bit-bang bridge.
- Implements the IEEE 1149.1 16-state controller with three data registers: IDCODE, BYPASS and a USER data register.
- The USER register exchanges a word with fabric logic, so host software can peek and poke an eFPGA or SoC register over the existing USB JTAG channel.

Parameters:
IR_LEN, 5, instruction register width (>=2)
IDCODE_VAL, 32'h1BEEF001, value returned by IDCODE; bit 0 must be 1
USER_WIDTH, 32, USER data register width
SYNC_STAGES, 2, synchronizer flops on each JTAG input (>=2)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
tck_i  in  1  JTAG TCK, asynchronous to clk_i
tms_i  in  1  JTAG TMS
tdi_i  in  1  JTAG TDI
trst_ni  in  1  JTAG TRST, active-low, asynchronous
tdo_o  out  1  JTAG TDO
tdo_oe_o  out  1  TDO drive enable; high only in SHIFT_IR/SHIFT_DR
tap_state_o  out  4  current TAP state (IEEE encoding)
user_rd_data_i  in  USER_WIDTH  word loaded on Capture-DR under USER
user_wr_data_o  out  USER_WIDTH  word delivered on Update-DR under USER
user_wr_valid_o  out  1  one-clk_i pulse: user_wr_data_o updated
srst_o  out  1  system reset request (see Optional Feature)

Behaviour:
- Reset (rst_n_i low, asynchronous): tap_state_o=4'hF (TLR), IR=IDCODE (5'b00001), tdo_o=0, tdo_oe_o=0, user_wr_data_o=0, user_wr_valid_o=0, srst_o=0.
- Clocking: release from reset is synchronous to clk_i.
- Input synchronization: tck, tms, tdi and trst_n each pass through SYNC_STAGES flops.
- Edge detection: tck_rise = synced TCK 1 with previous 0; tck_fall = the converse. Rise and fall never coincide.
- TCK rate: valid operation requires TCK high and low phases of >=3 clk_i cycles each.
- TRST: synced trst_n low forces TLR, IR=IDCODE, tdo_oe_o=0 and srst_o=0 on the next clk_i edge; it overrides any edge in that cycle.
- State encoding (hex):
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPD_IR=D
- State transitions follow IEEE 1149.1 and advance only on tck_rise, using synced TMS. Five consecutive TMS=1 rises reach TLR from any state.
- Actions on tck_rise, by the state being exited:
  - CAP_IR: IR shift register loads {0…,2'b01}.
  - SHIFT_IR: IR shift register shifts right, MSB <- TDI.
  - CAP_DR: selected DR loads (IDCODE_VAL, 1'b0 for BYPASS, or user_rd_data_i).
  - SHIFT_DR: selected DR shifts right, MSB <- TDI.
- Actions on tck_fall:
  - In SHIFT_IR/SHIFT_DR: tdo_o <- LSB of the active shift register, tdo_oe_o=1.
  - Otherwise: tdo_oe_o=0 and tdo_o holds its value.
  - In UPD_IR: IR <- IR shift register.
  - In UPD_DR with IR=USER (5'b01000): user_wr_data_o <- USER shift register, and user_wr_valid_o=1 for exactly that clk_i cycle.
- Instruction decode:
  - 00001 selects IDCODE.
  - 01000 selects USER.
  - All-ones and any unrecognised code select BYPASS (1-bit DR).
- Entering TLR by TMS forces IR=IDCODE; user_wr_data_o is retained.
- Reset mid-shift: a partially shifted value is discarded and no update pulse is issued.

Optional Feature:
- Macro: JTAG_TAP_SRST_EN.
- Defined: instruction 5'b00010 selects a 1-bit SRST DR. Capture loads the current srst_o. On Update-DR, srst_o <- the shifted bit; it holds until the next update, TLR, TRST or rst_n_i.
- Undefined: srst_o is tied 0 and 5'b00010 decodes as BYPASS.

Test Plan:
- Reset, then shift 32 DR bits with TDI=0 (IR holds IDCODE after reset) -> TDO stream LSB-first equals 32'h1BEEF001; tdo_oe_o high only during SHIFT_DR.
- Load IR=11111, shift pattern 1,0,1,1 through DR -> TDO returns 0,1,0,1 (1-cycle BYPASS delay).
- IR=01000, user_rd_data_i=32'hA5A5_0F0F, shift in 32'hDEAD_BEEF -> TDO yields A5A50F0F; after UPD_DR, user_wr_data_o=DEADBEEF and user_wr_valid_o pulses exactly once.
- From SHIFT_DR, apply 5 TMS=1 rises -> tap_state_o=F, IR=00001, no user_wr_valid_o pulse.
- Assert trst_ni mid SHIFT_IR -> tap_state_o=F within SYNC_STAGES+1 clk_i cycles; tdo_oe_o=0.
- With JTAG_TAP_SRST_EN defined: IR=00010, shift 1 -> srst_o=1 after UPD_DR; then 5 TMS=1 rises -> srst_o=0.
